// File: rtl/grp_sched_top.sv
// -----------------------------------------------------------------------------
// grp_sched_top
//
// Top-level group scheduler. Arbitrates among GRID*GRID groups with a
// round-robin pointer, holds a single grant until the granted group signals
// done, drops its request, or the grant times out, then broadcasts a one-cycle
// release pulse before the next arbitration.
//
// Parameters
//   GRID   groups per side; N = GRID*GRID groups, index g = row*GRID + col
//   TMO    grant timeout in cycles (0 disables the timeout)
//   TMO_W  width of the grant cycle counter (TMO <= 2**TMO_W - 1)
//
// Ports
//   clk_i      clock, all state on the rising edge
//   reset_i    asynchronous, active-low reset
//   enable_i   permits new grants; does not abort a grant in progress
//   req_i      per-group request  [row][col]
//   done_i     per-group done     [row][col]; only the granted group's bit counts
//   gnt_o      one-hot grant      [row][col]
//   release_o  one-cycle pulse when a grant ends
//   gx_o/gy_o  row / column of the current (or last) grant
//   active_o   high while a grant is held
//   timeout_o  one-cycle pulse, coincident with release_o, on timeout
// -----------------------------------------------------------------------------
module grp_sched_top #(
    parameter int GRID  = 2,
    parameter int TMO   = 64,
    parameter int TMO_W = 8
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           enable_i,
    input  logic [GRID-1:0][GRID-1:0]      req_i,
    input  logic [GRID-1:0][GRID-1:0]      done_i,
    output logic [GRID-1:0][GRID-1:0]      gnt_o,
    output logic                           release_o,
    output logic [((GRID > 1) ? $clog2(GRID) : 1)-1:0] gx_o,
    output logic [((GRID > 1) ? $clog2(GRID) : 1)-1:0] gy_o,
    output logic                           active_o,
    output logic                           timeout_o
);

    localparam int N  = GRID * GRID;
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int XW = (GRID > 1) ? $clog2(GRID) : 1;

    localparam bit             TMO_EN   = (TMO != 0);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TMO > 0) ? TMO - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    // Registered state and outputs
    state_t            r_state;
    logic [N-1:0]      r_gnt;
    logic [PW-1:0]     r_win;
    logic [PW-1:0]     r_ptr;
    logic [TMO_W-1:0]  r_cnt;
    logic [XW-1:0]     r_gx;
    logic [XW-1:0]     r_gy;
    logic              r_release;
    logic              r_timeout;
    logic              r_active;

    // Next-state values
    state_t            w_state_nxt;
    logic [N-1:0]      w_gnt_nxt;
    logic [PW-1:0]     w_win_nxt;
    logic [PW-1:0]     w_ptr_nxt;
    logic [TMO_W-1:0]  w_cnt_nxt;
    logic [XW-1:0]     w_gx_nxt;
    logic [XW-1:0]     w_gy_nxt;
    logic              w_release_nxt;
    logic              w_timeout_nxt;

    // Flattened request/done; packed [row][col] flattens to row*GRID + col
    logic [N-1:0]      w_req;
    logic [N-1:0]      w_done;
    assign w_req  = req_i;
    assign w_done = done_i;

    // Round-robin search: candidates (ptr+1), (ptr+2), ... (ptr+N), all mod N
    logic              w_found;
    logic [PW-1:0]     w_sel;
    logic [PW-1:0]     w_idx;

    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        for (int i = 1; i <= N; i++) begin
            w_idx = PW'((int'(r_ptr) + i) % N);
            if (!w_found && w_req[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    logic w_win_req;
    logic w_win_done;
    logic w_tmo_hit;
    assign w_win_req  = w_req[r_win];
    assign w_win_done = w_done[r_win];
    assign w_tmo_hit  = TMO_EN && (r_cnt == TMO_LAST);

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_nxt     = r_gnt;
        w_win_nxt     = r_win;
        w_ptr_nxt     = r_ptr;
        w_cnt_nxt     = r_cnt;
        w_gx_nxt      = r_gx;
        w_gy_nxt      = r_gy;
        w_release_nxt = 1'b0;
        w_timeout_nxt = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_gnt_nxt = '0;
                if (enable_i && w_found) begin
                    w_state_nxt       = S_GRANT;
                    w_gnt_nxt[w_sel]  = 1'b1;
                    w_win_nxt         = w_sel;
                    w_gx_nxt          = XW'(int'(w_sel) / GRID);
                    w_gy_nxt          = XW'(int'(w_sel) % GRID);
                    w_cnt_nxt         = '0;
                end
            end

            S_GRANT: begin
                // Priority: done beats request drop beats timeout, so a done
                // arriving on the expiry cycle never reports a timeout.
                if (w_win_done || !w_win_req || w_tmo_hit) begin
                    w_state_nxt   = S_RELEASE;
                    w_gnt_nxt     = '0;
                    w_release_nxt = 1'b1;
                    w_ptr_nxt     = r_win;
                    w_timeout_nxt = !w_win_done && w_win_req && w_tmo_hit;
                end else if (r_cnt != {TMO_W{1'b1}}) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            S_RELEASE: begin
                w_state_nxt = S_IDLE;
                w_gnt_nxt   = '0;
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state   <= S_IDLE;
            r_gnt     <= '0;
            r_win     <= '0;
            r_ptr     <= PW'(N - 1);
            r_cnt     <= '0;
            r_gx      <= '0;
            r_gy      <= '0;
            r_release <= 1'b0;
            r_timeout <= 1'b0;
            r_active  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_gnt     <= w_gnt_nxt;
            r_win     <= w_win_nxt;
            r_ptr     <= w_ptr_nxt;
            r_cnt     <= w_cnt_nxt;
            r_gx      <= w_gx_nxt;
            r_gy      <= w_gy_nxt;
            r_release <= w_release_nxt;
            r_timeout <= w_timeout_nxt;
            r_active  <= (w_state_nxt == S_GRANT);
        end
    end

    assign gnt_o     = r_gnt;
    assign release_o = r_release;
    assign timeout_o = r_timeout;
    assign active_o  = r_active;
    assign gx_o      = r_gx;
    assign gy_o      = r_gy;

endmodule

// File: tb/tb_grp_sched_top.sv
// -----------------------------------------------------------------------------
// tb_grp_sched_top
//
// Directed stimulus for grp_sched_top (GRID=2, TMO=8). The stimulus process
// pushes the expected grant / release / abort events into a queue as it drives
// inputs; an independent monitor samples the outputs on the falling edge,
// detects those events and compares them against the queue head, and checks
// per-cycle invariants (one-hot grant, active_o, held grant and coordinates).
// -----------------------------------------------------------------------------
module tb_grp_sched_top;

    localparam int GRID  = 2;
    localparam int TMO   = 8;
    localparam int TMO_W = 8;

    logic       clk;
    logic       reset_i;
    logic       enable;
    logic [3:0] req_v;
    logic [3:0] done_v;
    logic [3:0] gnt_v;
    logic       release_v;
    logic [0:0] gx_v;
    logic [0:0] gy_v;
    logic       active_v;
    logic       timeout_v;

    grp_sched_top #(
        .GRID  (GRID),
        .TMO   (TMO),
        .TMO_W (TMO_W)
    ) dut (
        .clk_i     (clk),
        .reset_i   (reset_i),
        .enable_i  (enable),
        .req_i     (req_v),
        .done_i    (done_v),
        .gnt_o     (gnt_v),
        .release_o (release_v),
        .gx_o      (gx_v),
        .gy_o      (gy_v),
        .active_o  (active_v),
        .timeout_o (timeout_v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {EV_NONE = 0, EV_GNT = 1, EV_REL = 2, EV_ABORT = 3} ev_e;

    typedef struct {
        ev_e kind;
        int  gnt;
        int  gx;
        int  gy;
        int  gap;   // expected idle samples before a grant; -1 = don't care
        int  len;   // expected grant samples before a release
        int  tmo;   // expected timeout_o on the release cycle
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_gnt(input int g, input int gap);
        exp_t e;
        e.kind = EV_GNT; e.gnt = (1 << g); e.gx = g / GRID; e.gy = g % GRID;
        e.gap = gap; e.len = 0; e.tmo = 0;
        exp_q.push_back(e);
    endtask

    task automatic push_rel(input int tmo, input int len);
        exp_t e;
        e.kind = EV_REL; e.gnt = 0; e.gx = 0; e.gy = 0;
        e.gap = -1; e.len = len; e.tmo = tmo;
        exp_q.push_back(e);
    endtask

    task automatic push_abort();
        exp_t e;
        e.kind = EV_ABORT; e.gnt = 0; e.gx = 0; e.gy = 0;
        e.gap = -1; e.len = 0; e.tmo = 0;
        exp_q.push_back(e);
    endtask

    task automatic pop_exp(output exp_t e, output bit ok);
        e.kind = EV_NONE; e.gnt = 0; e.gx = 0; e.gy = 0;
        e.gap = -1; e.len = 0; e.tmo = 0;
        ok = 1'b0;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_event: got an output event, expected none at %0t", $time);
        end else begin
            e  = exp_q.pop_front();
            ok = 1'b1;
        end
    endtask

    // ---------------------------------------------------------------- monitor
    exp_t       m_e;
    bit         m_ok;
    logic [3:0] m_prev = '0;
    int         m_gap = 0;
    bit         m_gap_ok = 1'b0;
    int         m_len = 0;
    int         m_gx = 0;
    int         m_gy = 0;

    always @(negedge clk) begin
        if (!reset_i) begin
            check("rst_gnt", int'(gnt_v), 0);
            check("rst_rel", int'(release_v), 0);
            if (m_prev != 4'b0) begin
                pop_exp(m_e, m_ok);
                if (m_ok) check("abort_kind", int'(m_e.kind), int'(EV_ABORT));
            end
            m_prev   = '0;
            m_gap_ok = 1'b0;
            m_gap    = 0;
            m_len    = 0;
            m_gx     = 0;
            m_gy     = 0;
        end else begin
            check("onehot", int'($countones(gnt_v) <= 1), 1);
            check("active", int'(active_v), int'(|gnt_v));

            if (release_v) begin
                pop_exp(m_e, m_ok);
                if (m_ok) begin
                    check("rel_kind", int'(m_e.kind), int'(EV_REL));
                    check("rel_timeout", int'(timeout_v), m_e.tmo);
                    check("rel_len", m_len, m_e.len);
                end
                check("rel_gnt", int'(gnt_v), 0);
            end else begin
                check("timeout_stray", int'(timeout_v), 0);
            end

            if (gnt_v != 4'b0 && m_prev == 4'b0) begin
                pop_exp(m_e, m_ok);
                if (m_ok) begin
                    check("gnt_kind", int'(m_e.kind), int'(EV_GNT));
                    check("gnt_value", int'(gnt_v), m_e.gnt);
                    if (m_e.gap >= 0 && m_gap_ok) check("gnt_gap", m_gap, m_e.gap);
                    m_gx = m_e.gx;
                    m_gy = m_e.gy;
                end
                m_len = 1;
            end else if (gnt_v != 4'b0) begin
                check("gnt_hold", int'(gnt_v), int'(m_prev));
                m_len++;
            end else begin
                if (m_prev != 4'b0) begin
                    check("end_has_release", int'(release_v), 1);
                    m_gap    = 1;
                    m_gap_ok = 1'b1;
                end else begin
                    m_gap++;
                end
            end

            check("gx", int'(gx_v), m_gx);
            check("gy", int'(gy_v), m_gy);
            m_prev = gnt_v;
        end
    end

    // --------------------------------------------------------------- stimulus
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        int g;
        reset_i = 1'b0;
        enable  = 1'b0;
        req_v   = '0;
        done_v  = '0;

        tick(3);
        check("reset_gnt", int'(gnt_v), 0);
        check("reset_release", int'(release_v), 0);
        check("reset_timeout", int'(timeout_v), 0);
        check("reset_active", int'(active_v), 0);
        check("reset_gx", int'(gx_v), 0);
        check("reset_gy", int'(gy_v), 0);
        reset_i = 1'b1;
        tick(1);

        // Round-robin over all four groups, done 3 cycles into each grant
        req_v  = 4'b1111;
        enable = 1'b1;
        push_gnt(0, -1);
        tick(1);
        for (int k = 0; k < 5; k++) begin
            g = k % 4;
            tick(2);
            done_v = 4'(1 << g);
            push_rel(0, 3);
            if (k < 4) push_gnt((k + 1) % 4, 2);
            tick(1);
            done_v = '0;
            if (k == 4) req_v = '0;
            tick(2);
        end

        // Lone request from group 2: 8-cycle timeout, re-grant, then req drop
        req_v = 4'b0100;
        push_gnt(2, -1);
        push_rel(1, 8);
        push_gnt(2, 2);
        tick(12);
        req_v = 4'b0000;
        push_rel(0, 2);
        tick(1);

        // Pointer now at 2, so group 3 wins next
        req_v = 4'b1111;
        push_gnt(3, 2);
        tick(3);

        // Asynchronous reset in the middle of the group-3 grant
        push_abort();
        reset_i = 1'b0;
        #1;
        check("async_gnt", int'(gnt_v), 0);
        check("async_release", int'(release_v), 0);
        check("async_active", int'(active_v), 0);
        check("async_gx", int'(gx_v), 0);
        check("async_gy", int'(gy_v), 0);
        tick(2);
        req_v = 4'b1001;
        push_gnt(0, -1);
        reset_i = 1'b1;

        // enable low during the grant: grant still completes, no new grant
        tick(1);
        enable = 1'b0;
        tick(1);
        done_v = 4'b0001;
        push_rel(0, 2);
        tick(1);
        done_v = '0;
        req_v  = 4'b1110;
        tick(5);
        enable = 1'b1;
        push_gnt(1, 6);

        // Group 1: foreign done ignored, own done on the expiry cycle wins
        tick(2);
        done_v = 4'b1000;
        tick(1);
        done_v = '0;
        tick(5);
        done_v = 4'b0010;
        push_rel(0, 8);
        tick(1);
        done_v = '0;
        req_v  = '0;
        tick(5);

        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/grp_sched_top.md
GRP_SCHED_TOP -- requirements
Module: grp_sched_top

Interface
REQ-001 SHALL have parameter GRID, default 2: groups per side; N = GRID*GRID groups, indexed g = row*GRID + col.
REQ-002 SHALL have parameter TMO, default 64: grant timeout in cycles; 0 disables timeout.
REQ-003 SHALL have parameter TMO_W, default 8: timeout counter width; TMO <= 2**TMO_W - 1.
REQ-004 clk_i  input  1  clock; all state on rising edge.
REQ-005 reset_i  input  1  reset, asynchronous assert, active-low.
REQ-006 enable_i  input  1  permits new grants; low blocks arbitration only.
REQ-007 req_i  input  [GRID-1:0][GRID-1:0]  per-group request (group req_o from level-1 groups).
REQ-008 done_i  input  [GRID-1:0][GRID-1:0]  per-group release/done (group grp_release_o).
REQ-009 gnt_o  output  [GRID-1:0][GRID-1:0]  one-hot group grant (drives group enable / gnt_top_i).
REQ-010 release_o  output  1  one-cycle release pulse to all groups (drives grp_release_i).
REQ-011 gx_o, gy_o  output  $clog2(GRID) each  row/column of current grant; hold last value when idle.
REQ-012 active_o  output  1  high while state is GRANT.
REQ-013 timeout_o  output  1  one-cycle pulse when a grant is ended by timeout.

Function
REQ-014 SHALL implement FSM states IDLE, GRANT, RELEASE; all outputs registered.
REQ-015 IDLE: gnt_o = 0; if enable_i and |req_i, select winner by round-robin, go to GRANT next cycle with gnt_o one-hot at winner (1-cycle latency req -> grant).
REQ-016 Round-robin: search starts at index (ptr+1) mod N, ascending with wrap; first set req_i wins; ptr = last granted index, reset value N-1 (so index 0 wins first).
REQ-017 GRANT: gnt_o, gx_o, gy_o held constant; cycle counter cnt increments from 0 (cleared on GRANT entry), saturating at 2**TMO_W-1.
REQ-018 GRANT -> RELEASE when done_i[winner] = 1; done_i of non-granted groups SHALL be ignored.
REQ-019 GRANT -> RELEASE when req_i[winner] drops to 0 with no done_i[winner]; no timeout_o.
REQ-020 GRANT -> RELEASE when TMO != 0 and cnt == TMO-1 with no done_i[winner]; timeout_o = 1 on the RELEASE cycle.
REQ-021 Simultaneous done_i[winner] and timeout expiry: done wins, timeout_o = 0.
REQ-022 RELEASE (exactly one cycle): gnt_o = 0, release_o = 1, ptr <= winner, then IDLE; minimum gap between consecutive grants is 2 cycles with gnt_o = 0.
REQ-023 enable_i low in GRANT SHALL NOT abort the grant; it only prevents the IDLE -> GRANT transition.
REQ-024 gnt_o SHALL never have more than one bit set; active_o = |gnt_o at all times.
REQ-025 Requests changing in IDLE SHALL be sampled on the arbitration edge only; no lookahead across RELEASE.

Reset
REQ-026 reset_i low SHALL asynchronously force: state IDLE, gnt_o = 0, release_o = 0, timeout_o = 0, active_o = 0, gx_o = gy_o = 0, cnt = 0, ptr = N-1.
REQ-027 Reset mid-GRANT SHALL drop gnt_o immediately without a release_o pulse; first grant after deassertion follows REQ-015/016 from index 0.

Verification (GRID=2, TMO=8)
REQ-028 After reset, req_i = 4'b1111 constant, each done_i pulsed 3 cycles into its grant -> grants in order 0,1,2,3,0; release_o once per grant; 2 idle cycles between grants.
REQ-029 req_i[2] only, no done -> gnt_o[2] for 8 cycles, then RELEASE with timeout_o = 1 and release_o = 1 on same cycle; re-grant to 2 two cycles later.
REQ-030 Grant to group 1; done_i[3] pulsed -> ignored, grant held; then done_i[1] together with cnt == 7 -> release, timeout_o = 0.
REQ-031 Grant to group 0, enable_i low -> grant completes on done_i[0]; no new grant while enable_i low despite req_i = 4'b1110; enable_i high -> group 1 granted next cycle.
REQ-032 Grant to group 3, reset_i asserted asynchronously mid-cycle -> gnt_o = 0 before next clock edge, no release_o; after release with req_i = 4'b1001, group 0 granted first.
REQ-033 Grant to group 2, req_i[2] dropped at cycle 2 -> RELEASE next cycle, timeout_o = 0, ptr = 2.
